// File: rtl/ps2_paddle_receiver.sv
// PS/2 device-to-host frame receiver that turns make/break scan codes into
// held-key levels for both Pong paddles plus a game-reset request.
module ps2_paddle_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter logic [7:0]  P1_UP_CODE     = 8'h1D,
    parameter logic [7:0]  P1_DOWN_CODE   = 8'h1B,
    parameter logic [7:0]  P2_UP_CODE     = 8'h75,
    parameter logic [7:0]  P2_DOWN_CODE   = 8'h72,
    parameter logic [7:0]  RESET_CODE     = 8'h29
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] scanCode,
    output logic       scanValid,
    output logic       frameError,
    output logic       p1Up,
    output logic       p1Down,
    output logic       p2Up,
    output logic       p2Down,
    output logic       gameReset
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             parityBit;
    logic [CNT_W-1:0] toCnt;
    logic             breakPending;
    logic             extPending;

    logic ps2ClkMeta, ps2ClkSync, ps2ClkPrev;
    logic ps2DataMeta, ps2DataSync;
    logic fallEdge;
    logic frameGood;

    // Two-flop synchronizers; reset to the idle-high line level so release never fakes an edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ps2ClkMeta  <= 1'b1;
            ps2ClkSync  <= 1'b1;
            ps2ClkPrev  <= 1'b1;
            ps2DataMeta <= 1'b1;
            ps2DataSync <= 1'b1;
        end else begin
            ps2ClkMeta  <= ps2Clk;
            ps2ClkSync  <= ps2ClkMeta;
            ps2ClkPrev  <= ps2ClkSync;
            ps2DataMeta <= ps2Data;
            ps2DataSync <= ps2DataMeta;
        end
    end

    assign fallEdge  = ps2ClkPrev & ~ps2ClkSync;
    assign frameGood = ps2DataSync & ((^shiftReg) ^ parityBit);

    // Frame FSM, timeout watchdog and scan-code decode
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            bitCnt       <= 3'd0;
            shiftReg     <= 8'h00;
            parityBit    <= 1'b0;
            toCnt        <= '0;
            breakPending <= 1'b0;
            extPending   <= 1'b0;
            scanCode     <= 8'h00;
            scanValid    <= 1'b0;
            frameError   <= 1'b0;
            p1Up         <= 1'b0;
            p1Down       <= 1'b0;
            p2Up         <= 1'b0;
            p2Down       <= 1'b0;
            gameReset    <= 1'b0;
        end else begin
            scanValid  <= 1'b0;
            frameError <= 1'b0;

            if (state == IDLE || fallEdge) begin
                toCnt <= '0;
            end else if (toCnt != CNT_MAX) begin
                toCnt <= toCnt + CNT_W'(1);
            end

            if (fallEdge) begin
                case (state)
                    IDLE: begin
                        if (!ps2DataSync) begin
                            state  <= DATA;
                            bitCnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shiftReg <= {ps2DataSync, shiftReg[7:1]};
                        if (bitCnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        parityBit <= ps2DataSync;
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (frameGood) begin
                            scanCode  <= shiftReg;
                            scanValid <= 1'b1;
                            if (shiftReg == BREAK_PREFIX) begin
                                breakPending <= 1'b1;
                            end else if (shiftReg == EXT_PREFIX) begin
                                extPending <= 1'b1;
                            end else begin
                                // Plain codes and E0-extended codes live in separate tables
                                if (!extPending) begin
                                    if (shiftReg == P1_UP_CODE)   p1Up      <= ~breakPending;
                                    if (shiftReg == P1_DOWN_CODE) p1Down    <= ~breakPending;
                                    if (shiftReg == RESET_CODE)   gameReset <= ~breakPending;
                                end else begin
                                    if (shiftReg == P2_UP_CODE)   p2Up      <= ~breakPending;
                                    if (shiftReg == P2_DOWN_CODE) p2Down    <= ~breakPending;
                                end
                                breakPending <= 1'b0;
                                extPending   <= 1'b0;
                            end
                        end else begin
                            frameError   <= 1'b1;
                            breakPending <= 1'b0;
                            extPending   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && toCnt == CNT_MAX) begin
                // Abandon a stalled partial frame
                state        <= IDLE;
                frameError   <= 1'b1;
                breakPending <= 1'b0;
                extPending   <= 1'b0;
            end
        end
    end

endmodule
